// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the parametrised priority / round-robin encoder.
// The clog2 helper sizes the encoded index on tools without a usable $clog2.
package prio_enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Returns ceil(log2(value)), with a floor of 1 so that N=1 still yields a 1-bit index.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: lowest set request at or above ptr, else lowest set request overall.
// Purely combinational; the caller owns the pointer register.
module rr_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [N-1:0] masked;
    logic [W-1:0] masked_idx;
    logic [W-1:0] plain_idx;
    logic         masked_any;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign masked[gi] = req[gi] && (gi >= int'(ptr));
        end
    endgenerate

    // Walk downwards so the last hit is the lowest set index.
    always_comb begin
        masked_idx = '0;
        plain_idx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (masked[i]) begin
                masked_idx = W'(i);
            end
            if (req[i]) begin
                plain_idx = W'(i);
            end
        end
    end

    assign masked_any = |masked;
    assign any        = |req;
    assign idx        = masked_any ? masked_idx : plain_idx;

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) encoder with valid/ready output, multi-request flag,
// and selectable fixed-priority (highest index) or round-robin arbitration.
module prio_encoder_rr
    import prio_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_code,
    output logic [N-1:0] out_grant,
    output logic         out_multi
);

    logic         valid_q, valid_d;
    logic [W-1:0] code_q, code_d;
    logic [N-1:0] grant_q, grant_d;
    logic         multi_q, multi_d;
    logic [W-1:0] rr_ptr_q, rr_ptr_d;

    logic         load;
    logic [W-1:0] fixed_idx;
    logic [W-1:0] rr_idx;
    logic         rr_any;
    logic         has_req;
    logic [W-1:0] winner;

    rr_pick #(
        .N (N),
        .W (W)
    ) u_rr_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .idx (rr_idx),
        .any (rr_any)
    );

    // Ascending walk: the last hit is the highest set index.
    always_comb begin
        fixed_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                fixed_idx = W'(i);
            end
        end
    end

    assign load    = ~valid_q | out_ready;
    assign has_req = (mode == MODE_RR) ? rr_any : |req;
    assign winner  = (mode == MODE_RR) ? rr_idx : fixed_idx;

    always_comb begin
        valid_d  = valid_q;
        code_d   = code_q;
        grant_d  = grant_q;
        multi_d  = multi_q;
        rr_ptr_d = rr_ptr_q;
        if (load) begin
            if (has_req) begin
                valid_d = 1'b1;
                code_d  = winner;
                grant_d = N'(1) << winner;
                multi_d = |(req & (req - N'(1)));
                if (mode == MODE_RR) begin
                    // Explicit wrap keeps the pointer inside 0..N-1 for non-power-of-two N.
                    rr_ptr_d = (winner == W'(N - 1)) ? '0 : winner + W'(1);
                end
            end else begin
                valid_d = 1'b0;
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            code_q   <= '0;
            grant_q  <= '0;
            multi_q  <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            code_q   <= code_d;
            grant_q  <= grant_d;
            multi_q  <= multi_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_code  = code_q;
    assign out_grant = grant_q;
    assign out_multi = multi_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr: an N=8 instance and an N=5 instance for the wrap case.
module tb_prio_encoder_rr;

    logic       clk;
    logic       rst;
    logic [7:0] req8;
    logic       mode8;
    logic       ready8;
    logic       valid8;
    logic [2:0] code8;
    logic [7:0] grant8;
    logic       multi8;
    logic [4:0] req5;
    logic       mode5;
    logic       ready5;
    logic       valid5;
    logic [2:0] code5;
    logic [4:0] grant5;
    logic       multi5;

    int n_checks;
    int n_fail;

    prio_encoder_rr #(.N(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .req       (req8),
        .mode      (mode8),
        .out_ready (ready8),
        .out_valid (valid8),
        .out_code  (code8),
        .out_grant (grant8),
        .out_multi (multi8)
    );

    prio_encoder_rr #(.N(5)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .req       (req5),
        .mode      (mode5),
        .out_ready (ready5),
        .out_valid (valid5),
        .out_code  (code5),
        .out_grant (grant5),
        .out_multi (multi5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if (valid8 !== 1'b0 || code8 !== 3'd0 || grant8 !== 8'h00 || multi8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: valid=%b code=%0d grant=%h multi=%b, required 0/0/00/0",
                     valid8, code8, grant8, multi8);
        end
        @(negedge clk);
        rst = 1'b0;
        // Advance the RR pointer to 4, then leave a stalled fixed result with code 5.
        req8 = 8'h08; mode8 = 1'b1; ready8 = 1'b1;
        step();
        req8 = 8'h20; mode8 = 1'b0;
        step();
        ready8 = 1'b0;
        n_checks++;
        if (valid8 !== 1'b1 || code8 !== 3'd5) begin
            n_fail++;
            $display("FAIL reset_setup: valid=%b code=%0d, required 1/5", valid8, code8);
        end
        pulse_reset();
        n_checks++;
        if (valid8 !== 1'b0 || code8 !== 3'd0 || grant8 !== 8'h00 || multi8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b code=%0d grant=%h multi=%b, required 0/0/00/0",
                     valid8, code8, grant8, multi8);
        end
        @(negedge clk);
        // Pointer back at 0: RR over {0,7} must choose 0, not 7.
        req8 = 8'h81; mode8 = 1'b1; ready8 = 1'b1;
        step();
        n_checks++;
        if (valid8 !== 1'b1 || code8 !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_rr_ptr: valid=%b code=%0d, required 1/0", valid8, code8);
        end
        $display("test_reset done");
    endtask

    task automatic test_fixed();
        req8 = 8'b0010_0110; mode8 = 1'b0; ready8 = 1'b1;
        step();
        n_checks++;
        if (valid8 !== 1'b1 || code8 !== 3'd5 || grant8 !== 8'h20 || multi8 !== 1'b1) begin
            n_fail++;
            $display("FAIL fixed_multi: valid=%b code=%0d grant=%h multi=%b, required 1/5/20/1",
                     valid8, code8, grant8, multi8);
        end
        req8 = 8'h01;
        step();
        n_checks++;
        if (valid8 !== 1'b1 || code8 !== 3'd0 || grant8 !== 8'h01 || multi8 !== 1'b0) begin
            n_fail++;
            $display("FAIL fixed_single: valid=%b code=%0d grant=%h multi=%b, required 1/0/01/0",
                     valid8, code8, grant8, multi8);
        end
        $display("test_fixed done");
    endtask

    task automatic test_rr_rotation();
        logic [2:0] exp_code [5];
        logic [7:0] exp_grant [5];
        exp_code  = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2};
        exp_grant = '{8'h01, 8'h04, 8'h80, 8'h01, 8'h04};
        pulse_reset();
        @(negedge clk);
        req8 = 8'b1000_0101; mode8 = 1'b1; ready8 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (valid8 !== 1'b1 || code8 !== exp_code[k] || grant8 !== exp_grant[k] || multi8 !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_rot[%0d]: valid=%b code=%0d grant=%h multi=%b, required 1/%0d/%h/1",
                         k, valid8, code8, grant8, multi8, exp_code[k], exp_grant[k]);
            end
        end
        $display("test_rr_rotation done");
    endtask

    task automatic test_backpressure();
        req8 = 8'h08; mode8 = 1'b0; ready8 = 1'b1;
        step();
        ready8 = 1'b0; req8 = 8'h80;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (valid8 !== 1'b1 || code8 !== 3'd3 || grant8 !== 8'h08) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b code=%0d grant=%h, required 1/3/08",
                         k, valid8, code8, grant8);
            end
        end
        ready8 = 1'b1;
        step();
        n_checks++;
        if (valid8 !== 1'b1 || code8 !== 3'd7 || grant8 !== 8'h80) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b code=%0d grant=%h, required 1/7/80",
                     valid8, code8, grant8);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_empty();
        req8 = 8'h00; ready8 = 1'b1; mode8 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (valid8 !== 1'b0 || grant8 !== 8'h00) begin
                n_fail++;
                $display("FAIL empty[%0d]: valid=%b grant=%h, required 0/00", k, valid8, grant8);
            end
        end
        req8 = 8'h04;
        step();
        n_checks++;
        if (valid8 !== 1'b1 || code8 !== 3'd2 || grant8 !== 8'h04 || multi8 !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_resume: valid=%b code=%0d grant=%h multi=%b, required 1/2/04/0",
                     valid8, code8, grant8, multi8);
        end
        $display("test_empty done");
    endtask

    task automatic test_wrap_n5();
        logic [2:0] exp_code [6];
        logic       exp_mode [6];
        // RR 0,4,0 leaves the pointer at 1; fixed keeps it; RR then resumes from 1 and picks 4.
        exp_code = '{3'd0, 3'd4, 3'd0, 3'd4, 3'd4, 3'd4};
        exp_mode = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        pulse_reset();
        @(negedge clk);
        req5 = 5'b10001; ready5 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            mode5 = exp_mode[k];
            step();
            n_checks++;
            if (valid5 !== 1'b1 || code5 !== exp_code[k] || multi5 !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap5[%0d]: valid=%b code=%0d multi=%b, required 1/%0d/1",
                         k, valid5, code5, multi5, exp_code[k]);
            end
            n_checks++;
            if (dut5.rr_ptr_q > 3'd4) begin
                n_fail++;
                $display("FAIL wrap5_ptr[%0d]: rr_ptr=%0d, required <= 4", k, dut5.rr_ptr_q);
            end
        end
        $display("test_wrap_n5 done");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst    = 1'b0;
        req8   = '0; mode8 = 1'b0; ready8 = 1'b0;
        req5   = '0; mode5 = 1'b0; ready5 = 1'b0;
        test_reset();
        test_fixed();
        test_rr_rotation();
        test_backpressure();
        test_empty();
        test_wrap_n5();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
Parametrised N-to-log2(N) encoder that supersedes the fixed 4-to-2 combinational encoder. It adds a registered output, a valid/ready output handshake, a multi-request flag, and a selectable arbitration mode: fixed priority or round-robin. It sits between request-generating logic (buttons, interrupt lines, channel requests) and a single consumer that needs one encoded index per transfer.

Parameters:
N, 8, number of request lines; any value >= 2, power of two not required.
W, $clog2(N), width of the encoded index; derived, not overridden.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
req  input  N  request vector; bit i set = line i requesting; sampled only on a load cycle.
mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin; sampled only on a load cycle.
out_ready  input  1  consumer accepts the current output when out_valid && out_ready.
out_valid  output  1  out_code, out_grant and out_multi hold a valid result.
out_code  output  W  encoded index of the winning request line.
out_grant  output  N  one-hot form of out_code; zero when out_valid = 0.
out_multi  output  1  more than one req bit was set when the result was loaded.

Behaviour:
- Reset (async, any time, including mid-transfer): out_valid=0, out_code=0, out_grant=0, out_multi=0, rr_ptr=0. A pending, unaccepted result is discarded.
- load = ~out_valid | out_ready. Evaluated each cycle; when load=0, all outputs and rr_ptr hold (backpressure).
- On load with req != 0:
  - out_valid <= 1.
  - out_code <= winner; out_grant <= 1 << winner.
  - out_multi <= (popcount(req) > 1).
- On load with req == 0: out_valid <= 0, out_grant <= 0. out_code and out_multi hold their last value (don't-care).
- Latency: req to out_valid/out_code is exactly 1 clk. Full throughput, one result per cycle, when out_ready is held at 1.
- Winner in fixed mode (mode=0): highest set index in req. rr_ptr is not modified.
- Winner in round-robin mode (mode=1):
  - Lowest set index i with i >= rr_ptr.
  - If none exists, wrap: lowest set index overall.
  - On the same load, rr_ptr <= (winner == N-1) ? 0 : winner+1.
- rr_ptr:
  - Internal, range 0..N-1, W bits.
  - Never takes values >= N, including for non-power-of-two N.
  - Retained across mode switches. Changing mode takes effect on the next load.
- req changing while out_valid=1 and out_ready=0 has no effect until the next load. No combinational path from req to any output.
- Single request: out_multi=0. In RR mode the pointer still advances past the winner.
- out_ready asserted while out_valid=0 is legal and ignored.

Decomposition:
- Shared package prio_enc_pkg:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1 constants.
  - clog2 function for W when tools lack $clog2.
- One natural sub-module, rr_pick:
  - Combinational; inputs req[N], ptr[W]; outputs idx[W], any.
  - Implements the masked-then-unmasked lowest-set-bit search.
  - prio_encoder_rr instantiates it for RR mode; the fixed-priority search and the registers/handshake stay in the top.

Test Plan:
1. Reset mid-operation: N=8, out_valid=1, out_code=5, out_ready=0; pulse rst between clock edges -> out_valid=0, out_code=0, out_grant=0 immediately; first RR winner afterwards searches from ptr 0.
2. Fixed mode: req=8'b0010_0110, mode=0, out_ready=1 -> next cycle out_valid=1, out_code=5, out_grant=8'h20, out_multi=1. Then req=8'h01 -> out_code=0, out_multi=0.
3. Round-robin rotation: req=8'b1000_0101 held, mode=1, out_ready=1 -> successive out_code 0, 2, 7, 0, 2; out_multi=1 throughout.
4. Backpressure: out_valid=1, out_code=3, out_ready=0; change req to 8'h80 for 3 cycles -> out_code stays 3; raise out_ready -> next cycle out_code=7.
5. Empty request: after a transfer with req=0 and out_ready=1 -> out_valid=0 and out_grant=0 next cycle, held until req != 0.
6. Non-power-of-two wrap: N=5, W=3, mode=1, req=5'b10001 held -> out_code 0, 4, 0, 4; rr_ptr never exceeds 4. Switch mode=0 mid-stream -> out_code 4 repeatedly.
